// File: rtl/scumvcontroller_tx_arbiter.sv
// scumvcontroller_tx_arbiter: packet-atomic round-robin arbiter feeding one UART TX byte stream.
// Optional macro SCUMV_TX_ARB_HEADER_EN prepends a source tag byte to every packet.
`default_nettype none

module scumvcontroller_tx_arbiter #(
    parameter int unsigned ASC_PKT_LEN    = 1,
    parameter int unsigned STL_PKT_LEN    = 16,
    parameter int unsigned LOG_PKT_LEN    = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       asc_valid_i,
    input  logic [7:0] asc_data_i,
    output logic       asc_ready_o,
    input  logic       stl_valid_i,
    input  logic [7:0] stl_data_i,
    output logic       stl_ready_o,
    input  logic       log_valid_i,
    input  logic [7:0] log_data_i,
    output logic       log_ready_o,
    output logic [7:0] tx_data_o,
    output logic       tx_valid_o,
    input  logic       tx_ready_i,
    output logic [1:0] grant_o,
    output logic       busy_o,
    output logic       timeout_pulse_o,
    output logic [7:0] timeout_count_o
);

`ifdef SCUMV_TX_ARB_HEADER_EN
    typedef enum logic [1:0] {ST_IDLE, ST_FWD, ST_RELEASE, ST_HEADER} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_FWD, ST_RELEASE} state_t;
`endif

    localparam logic [7:0]  ASC_LEN   = ASC_PKT_LEN[7:0];
    localparam logic [7:0]  STL_LEN   = STL_PKT_LEN[7:0];
    localparam logic [7:0]  LOG_LEN   = LOG_PKT_LEN[7:0];
    localparam logic [31:0] WDOG_LAST = 32'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [1:0]  grant_q, grant_d;
    logic [1:0]  ptr_q, ptr_d;
    logic [7:0]  len_q, len_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] wdog_q, wdog_d;
    logic        tpulse_q, tpulse_d;
    logic [7:0]  tcount_q, tcount_d;

    logic [2:0]  req;
    logic        pick_vld;
    logic [1:0]  pick_idx;
    logic [7:0]  pick_len;
    logic        sel_valid;
    logic [7:0]  sel_data;

    assign req = {log_valid_i, stl_valid_i, asc_valid_i};

    // Search order starts just after the last owner and wraps, so the last owner goes last.
    always_comb begin
        pick_vld = |req;
        pick_idx = 2'd0;
        case (ptr_q)
            2'd0: pick_idx = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
            2'd1: pick_idx = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
            default: pick_idx = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
        endcase
        case (pick_idx)
            2'd0:    pick_len = ASC_LEN;
            2'd1:    pick_len = STL_LEN;
            default: pick_len = LOG_LEN;
        endcase
    end

    always_comb begin
        case (grant_q)
            2'd0: begin sel_valid = asc_valid_i; sel_data = asc_data_i; end
            2'd1: begin sel_valid = stl_valid_i; sel_data = stl_data_i; end
            2'd2: begin sel_valid = log_valid_i; sel_data = log_data_i; end
            default: begin sel_valid = 1'b0; sel_data = 8'h00; end
        endcase
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        ptr_d       = ptr_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        wdog_d      = wdog_q;
        tpulse_d    = 1'b0;
        tcount_d    = tcount_q;
        tx_valid_o  = 1'b0;
        tx_data_o   = 8'h00;
        asc_ready_o = 1'b0;
        stl_ready_o = 1'b0;
        log_ready_o = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    grant_d = pick_idx;
                    len_d   = pick_len;
                    cnt_d   = 8'd0;
                    wdog_d  = 32'd0;
`ifdef SCUMV_TX_ARB_HEADER_EN
                    state_d = ST_HEADER;
`else
                    state_d = ST_FWD;
`endif
                end
            end
`ifdef SCUMV_TX_ARB_HEADER_EN
            ST_HEADER: begin
                tx_valid_o = 1'b1;
                tx_data_o  = 8'hA1 + {6'd0, grant_q};
                if (tx_ready_i) begin
                    wdog_d  = 32'd0;
                    state_d = ST_FWD;
                end else if (wdog_q == WDOG_LAST) begin
                    state_d  = ST_RELEASE;
                    tpulse_d = 1'b1;
                    tcount_d = (tcount_q == 8'hFF) ? tcount_q : tcount_q + 8'd1;
                end else begin
                    wdog_d = wdog_q + 32'd1;
                end
            end
`endif
            ST_FWD: begin
                tx_valid_o  = sel_valid;
                tx_data_o   = sel_valid ? sel_data : 8'h00;
                asc_ready_o = (grant_q == 2'd0) & tx_ready_i;
                stl_ready_o = (grant_q == 2'd1) & tx_ready_i;
                log_ready_o = (grant_q == 2'd2) & tx_ready_i;
                if (sel_valid && tx_ready_i) begin
                    cnt_d  = cnt_q + 8'd1;
                    wdog_d = 32'd0;
                    if (cnt_q == len_q - 8'd1) begin
                        state_d = ST_RELEASE;
                    end
                end else if (wdog_q == WDOG_LAST) begin
                    state_d  = ST_RELEASE;
                    tpulse_d = 1'b1;
                    tcount_d = (tcount_q == 8'hFF) ? tcount_q : tcount_q + 8'd1;
                end else begin
                    wdog_d = wdog_q + 32'd1;
                end
            end
            ST_RELEASE: begin
                ptr_d   = grant_q;
                grant_d = 2'd3;
                state_d = ST_IDLE;
            end
            default: begin
                grant_d = 2'd3;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= ST_IDLE;
            grant_q  <= 2'd3;
            ptr_q    <= 2'd2;
            len_q    <= 8'd0;
            cnt_q    <= 8'd0;
            wdog_q   <= 32'd0;
            tpulse_q <= 1'b0;
            tcount_q <= 8'd0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            ptr_q    <= ptr_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            wdog_q   <= wdog_d;
            tpulse_q <= tpulse_d;
            tcount_q <= tcount_d;
        end
    end

    assign grant_o         = grant_q;
    assign busy_o          = (state_q != ST_IDLE);
    assign timeout_pulse_o = tpulse_q;
    assign timeout_count_o = tcount_q;

endmodule

`default_nettype wire
